wb_port_arbiter: RTL

Round-robin arbiter that shares the single register-file write port among five result sources (ALU, load unit, PC+4, immediate/LUI, CSR). Each source presents a valid/ready write request. The block grants at most one request per cycle and registers the winner into a one-entry writeback slot. It drives the write-port strobe, destination register, data, and the 3-bit writeback-select code used by the 5:1 result mux.

---
 rtl/wb_pkg.sv | 31 +++
 rtl/wb_port_arbiter_rr_pick5.sv | 39 +++
 rtl/wb_port_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared writeback-select codes and source constants
// Purpose: writeback-select encoding shared by the decoder, result mux and
//          the write-port arbiter.
// Contents: NSRC, SEL_SRC0..SEL_SRC4, src_to_sel(), slot state type.
package wb_pkg;

  localparam int NSRC = 5;

  localparam logic [2:0] SEL_SRC0 = 3'b000;  // ALU
  localparam logic [2:0] SEL_SRC1 = 3'b001;  // load unit
  localparam logic [2:0] SEL_SRC2 = 3'b011;  // PC+4
  localparam logic [2:0] SEL_SRC3 = 3'b010;  // immediate / LUI
  localparam logic [2:0] SEL_SRC4 = 3'b110;  // CSR

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  function automatic logic [2:0] src_to_sel(input logic [2:0] idx);
    case (idx)
      3'd0:    return SEL_SRC0;
      3'd1:    return SEL_SRC1;
      3'd2:    return SEL_SRC2;
      3'd3:    return SEL_SRC3;
      3'd4:    return SEL_SRC4;
      default: return SEL_SRC0;
    endcase
  endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_pick5.sv
// rtl/wb_port_arbiter_rr_pick5.sv - combinational 5-way round-robin picker
// Purpose: picks the first set request at or after ptr, searching upward mod 5.
// Ports:
//   req   in  5  request vector
//   ptr   in  3  search start index (0..4)
//   grant out 5  one-hot winner, zero when no request
//   idx   out 3  winner index, 0 when no request
module rr_pick5 (
  input  logic [4:0] req,
  input  logic [2:0] ptr,
  output logic [4:0] grant,
  output logic [2:0] idx
);

  logic [3:0] sum;
  logic [2:0] cand;
  logic       found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < 5; i++) begin
      sum = {1'b0, ptr} + 4'(i);
      if (sum >= 4'd5) begin
        sum = sum - 4'd5;
      end
      cand = sum[2:0];
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - round-robin arbiter for the register-file write port
// Purpose: grants one of five result sources per cycle into a one-entry
//          writeback slot that drives the register-file write port.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/rd/data    per-source write requests (packed, source 0 in LSBs)
//   req_ready            per-source accept, one-hot or zero
//   flush                synchronous slot clear
//   wb_valid/wb_ready    writeback slot handshake
//   wb_we                register-file write strobe
//   wb_rd/wb_data/wb_sel slot contents and result-mux select code
module wb_port_arbiter #(
  parameter int NSRC = 5,
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSRC-1:0]   req_valid,
  input  logic [NSRC*5-1:0] req_rd,
  input  logic [NSRC*XLEN-1:0] req_data,
  output logic [NSRC-1:0]   req_ready,
  input  logic              flush,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic [2:0]        wb_sel
);

  import wb_pkg::*;

  slot_state_t state, state_nx;

  logic [2:0]      rr_ptr;
  logic [2:0]      win_idx;
  logic [NSRC-1:0] win_oh;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;
  logic            slot_free;
  logic            grant;
  logic            load;

  rr_pick5 u_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (win_oh),
    .idx   (win_idx)
  );

  always_comb begin
    win_rd   = '0;
    win_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (win_oh[i]) begin
        win_rd   = req_rd[i*5 +: 5];
        win_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  assign wb_valid  = (state == SLOT_FULL);
  assign wb_we     = wb_valid & wb_ready;
  assign slot_free = !wb_valid | wb_ready;
  // rst_n gates the grant so req_ready stays low while reset is held.
  assign grant     = rst_n & slot_free & !flush & (|req_valid);
  assign req_ready = grant ? win_oh : '0;
  // An x0 grant is accepted but never occupies the slot.
  assign load      = grant & (win_rd != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SLOT_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = SLOT_EMPTY;
    end else if (load) begin
      state_nx = SLOT_FULL;
    end else if (wb_we) begin
      state_nx = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_rd   <= '0;
      wb_data <= '0;
      wb_sel  <= SEL_SRC0;
      rr_ptr  <= '0;
    end else begin
      if (load) begin
        wb_rd   <= win_rd;
        wb_data <= win_data;
        wb_sel  <= src_to_sel(win_idx);
      end
      if (grant) begin
        rr_ptr <= (win_idx == 3'd4) ? 3'd0 : win_idx + 3'd1;
      end
    end
  end

endmodule
